// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential increment, branch redirect, stall hold,
// and a sticky fault state entered when fetch flags the driven PC as invalid.
module pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        inv_addr,
  input  logic        clear_fault,
  output logic [63:0] PC,
  output logic        pc_valid,
  output logic        fault,
  output logic [63:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= 64'h0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  // A taken branch outranks inv_addr and stall: the current fetch is wrong-path.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          count_d = count_q + 32'd1;
        end else if (inv_addr) begin
          state_d    = FAULT;
          fault_pc_d = pc_q;
        end else if (!stall) begin
          pc_d    = pc_q + 64'd4;
          count_d = count_q + 32'd1;
        end
      end
      FAULT: begin
        // fault_pc and fetch_count survive the clear for post-mortem inspection.
        if (clear_fault) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      default: begin
        state_d = RUN;
        pc_d    = RESET_PC;
      end
    endcase
  end

  assign PC          = pc_q;
  assign pc_valid    = (state_q == RUN);
  assign fault       = (state_q == FAULT);
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: hand-computed expectations checked with immediate
// assertions one time unit after each rising edge.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        inv_addr;
  logic        clear_fault;
  logic [63:0] pc;
  logic        pc_valid;
  logic        fault;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  pc_gen #(.RESET_PC(64'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inv_addr      (inv_addr),
    .clear_fault   (clear_fault),
    .PC            (pc),
    .pc_valid      (pc_valid),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .fetch_count   (fetch_count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] e_pc, input logic [31:0] e_cnt,
                         input logic e_fault, input logic [63:0] e_fpc);
    chk({tag, "_pc"}, pc, e_pc);
    chk({tag, "_cnt"}, {32'h0, fetch_count}, {32'h0, e_cnt});
    chk({tag, "_fault"}, {63'h0, fault}, {63'h0, e_fault});
    chk({tag, "_valid"}, {63'h0, pc_valid}, {63'h0, ~e_fault});
    chk({tag, "_fpc"}, fault_pc, e_fpc);
  endtask

  initial begin
    logic [63:0] exp_pc;
    logic [31:0] exp_cnt;

    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    inv_addr = 1'b0; clear_fault = 1'b0;
    step();
    step();
    chk_all("reset", 64'h0, 32'd0, 1'b0, 64'h0);

    // free run then a two-cycle stall at PC=8
    rst_n = 1'b1;
    step(); chk_all("run1", 64'h4, 32'd1, 1'b0, 64'h0);
    step(); chk_all("run2", 64'h8, 32'd2, 1'b0, 64'h0);
    stall = 1'b1;
    step(); chk_all("stall1", 64'h8, 32'd2, 1'b0, 64'h0);
    step(); chk_all("stall2", 64'h8, 32'd2, 1'b0, 64'h0);
    stall = 1'b0;
    step(); chk_all("run3", 64'hC, 32'd3, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) step();
    chk_all("run_to_20", 64'h20, 32'd8, 1'b0, 64'h0);

    // branch beats simultaneous stall and inv_addr
    branch_taken = 1'b1; branch_target = 64'h100; stall = 1'b1; inv_addr = 1'b1;
    step(); chk_all("br_prio", 64'h100, 32'd9, 1'b0, 64'h0);

    // misaligned redirect; fetch flags it on the following cycle
    stall = 1'b0; inv_addr = 1'b0; branch_target = 64'h102;
    step(); chk_all("br_mis", 64'h102, 32'd10, 1'b0, 64'h0);
    branch_taken = 1'b0; inv_addr = 1'b1;
    step(); chk_all("fault_in", 64'h102, 32'd10, 1'b1, 64'h102);

    // inputs other than clear_fault are ignored in FAULT
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h200; inv_addr = 1'b0;
    step(); chk_all("fault_hold1", 64'h102, 32'd10, 1'b1, 64'h102);
    stall = 1'b0; branch_taken = 1'b0; inv_addr = 1'b1;
    step(); chk_all("fault_hold2", 64'h102, 32'd10, 1'b1, 64'h102);

    inv_addr = 1'b0; clear_fault = 1'b1;
    step(); chk_all("clear", 64'h0, 32'd10, 1'b0, 64'h102);
    // clear_fault has no effect in RUN
    step(); chk_all("clear_run", 64'h4, 32'd11, 1'b0, 64'h102);
    clear_fault = 1'b0; inv_addr = 1'b1;
    step(); chk_all("fault2", 64'h4, 32'd11, 1'b1, 64'h4);

    // reset mid-FAULT with an active branch
    inv_addr = 1'b0; rst_n = 1'b0; branch_taken = 1'b1; branch_target = 64'h300;
    step(); chk_all("rst_fault", 64'h0, 32'd0, 1'b0, 64'h0);

    // 64-bit PC wrap
    rst_n = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); chk_all("br_top", 64'hFFFF_FFFF_FFFF_FFFC, 32'd1, 1'b0, 64'h0);
    branch_taken = 1'b0;
    step(); chk_all("pc_wrap", 64'h0, 32'd2, 1'b0, 64'h0);

    // long sequential run with a few random stalls
    exp_pc = 64'h0;
    exp_cnt = 32'd2;
    for (int i = 0; i < 1000; i++) begin
      stall = ($urandom_range(0, 7) == 0);
      if (!stall) begin
        exp_pc = exp_pc + 64'd4;
        exp_cnt = exp_cnt + 32'd1;
      end
      step();
    end
    stall = 1'b0;
    chk_all("long_run", exp_pc, exp_cnt, 1'b0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generation stage sitting directly upstream of instruction fetch. Holds the architectural fetch PC in a register and drives it to the fetch stage every cycle. Selects the next PC from sequential increment, branch redirect or stall hold, and enters a sticky fault state when fetch reports an invalid address. Also keeps a running count of accepted PC updates for debug and performance monitoring.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset and on fault clear.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hold the PC this cycle; back-pressure from downstream.
- branch_taken  in  1  redirect request from the branch-resolution stage.
- branch_target  in  64  redirect PC, sampled when branch_taken=1.
- inv_addr  in  1  fetch-stage flag for the PC currently driven; combinational, same cycle.
- clear_fault  in  1  leave FAULT and restart at RESET_PC.
- PC  out  64  current fetch PC, registered.
- pc_valid  out  1  PC is live for fetch; high only in RUN.
- fault  out  1  high in FAULT.
- fault_pc  out  64  PC that raised inv_addr, captured on FAULT entry.
- fetch_count  out  32  number of PC updates taken in RUN.

## Operation
- States: RUN, FAULT. The encoding is free, but it must be a registered state.
- Reset (rst_n=0 at an edge) sets:
  - state=RUN, PC=RESET_PC, fault_pc=0, fetch_count=0.
  - Reset overrides all other inputs.
- pc_valid = (state==RUN) and fault = (state==FAULT). Both are decoded directly from the state register.
- In RUN, one action is taken per edge, in this priority order:
  1. branch_taken=1: PC <= branch_target and fetch_count += 1. inv_addr and stall are ignored, because the current fetch is wrong-path.
  2. inv_addr=1: state <= FAULT, fault_pc <= PC. PC holds and fetch_count holds.
  3. stall=1: PC and fetch_count hold.
  4. Otherwise: PC <= PC + 4 and fetch_count += 1.
- In FAULT:
  - PC, fault_pc and fetch_count hold.
  - branch_taken, stall and inv_addr are ignored.
  - clear_fault=1: state <= RUN, PC <= RESET_PC. fault_pc is retained as a post-mortem value, and fetch_count is not cleared.
- clear_fault is ignored in RUN.
- branch_target is loaded unchecked. A misaligned or out-of-range target causes fetch to assert inv_addr on the next cycle, which then faults via rule 2.
- Arithmetic:
  - PC + 4 is modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  - fetch_count is modulo 2^32, so 32'hFFFF_FFFF wraps to 0.
  - No saturation on either.

## Timing
- PC is a register. A redirect asserted in cycle N appears on PC in cycle N+1, giving a redirect latency of 1.
- inv_addr is evaluated against the PC driven in the same cycle. The FAULT state and fault_pc are visible in the next cycle.
- There are no combinational paths from any input to any output.
- Stall has no latency: PC is unchanged on the edge where stall=1.
- Simultaneous branch_taken and inv_addr: branch wins and no fault is taken.
- Reset mid-FAULT: returns to RUN at RESET_PC and clears fault_pc and fetch_count.
- Reset during an active branch: reset wins and PC=RESET_PC.
- Throughput: one PC per cycle in RUN with no stall.

## Test plan
- Reset then free-run, RESET_PC=0:
  - PC sequence is 0, 4, 8, 12 over 4 cycles.
  - fetch_count is 3 after the third edge.
  - pc_valid=1 and fault=0 throughout.
- Stall for 2 cycles at PC=8:
  - PC stays 8 for those two edges, then goes to 12.
  - fetch_count does not increment during the stall.
- branch_taken with branch_target=64'h100, together with stall=1 and inv_addr=1 at PC=0x20:
  - Next PC is 0x100, fault=0, fetch_count+1.
- Redirect to misaligned 64'h102, with the fetch model asserting inv_addr:
  - One cycle later fault=1 and pc_valid=0, with fault_pc=0x102.
  - PC stays 0x102 while stall/branch inputs are toggled.
- From FAULT, pulse clear_fault:
  - PC=RESET_PC, state RUN, fault_pc still 0x102, fetch_count unchanged.
  - Then rst_n=0 for one edge: fault_pc=0 and fetch_count=0.
- Wrap cases:
  - Branch to 64'hFFFF_FFFF_FFFF_FFFC with inv_addr held 0: next PC is 0.
  - Preload fetch_count near 32'hFFFF_FFFF via a long run: it wraps to 0.
